pwm: RTL and testbench

Button-controlled PWM generator. Two active-low push-buttons raise or lower the duty cycle in fixed steps. The block drives a single PWM output at a fixed period. It sits between board push-buttons and a load such as an LED or motor driver, on the 50 MHz system clock.

---
 rtl/pwm.sv | 144 ++++++++++++++
 tb/tb_pwm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm.sv
`default_nettype none
// ============================================================================
//  Module      : pwm
//  Description : Button-controlled PWM generator. Two active-low push-buttons
//                are synchronised and debounced; each accepted press steps the
//                duty up or down with saturation. A free-running period
//                counter compares against a shadow duty that is only updated
//                at period boundaries, so every period is whole.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm #(
    parameter int unsigned PERIOD_CYCLES   = 100,
    parameter int unsigned DUTY_STEP       = 10,
    parameter int unsigned DUTY_RESET      = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_inc,
    input  logic pb_dec,
    output logic pwm_out
);

    localparam int unsigned CW  = $clog2(PERIOD_CYCLES);
    localparam int unsigned DW  = $clog2(PERIOD_CYCLES + 1);
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0]  c_cnt_last = CW'(PERIOD_CYCLES - 1);
    localparam logic [DW-1:0]  c_duty_max = DW'(PERIOD_CYCLES);
    localparam logic [DW-1:0]  c_duty_rst = DW'(DUTY_RESET);
    // A step larger than the period saturates identically to a step equal to it.
    localparam logic [DW-1:0]  c_step     = DW'((DUTY_STEP > PERIOD_CYCLES) ? PERIOD_CYCLES : DUTY_STEP);
    // Any duty at or above this value saturates to the maximum on increment.
    localparam logic [DW-1:0]  c_inc_lim  = c_duty_max - c_step;
    localparam logic [DBW-1:0] c_db_last  = DBW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] w_pb;
    logic [1:0] w_step;
    logic       w_inc;
    logic       w_dec;

    assign w_pb = {pb_dec, pb_inc};

    // Per-button conditioning: index 0 is increment, index 1 is decrement.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic           r_sync1;
        logic           r_sync2;
        logic           r_db;
        logic           r_db_q;
        logic [DBW-1:0] r_dcnt;
        logic           w_pressed;

        // Two-flop synchroniser; resets to the released level.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= w_pb[gi];
                r_sync2 <= r_sync1;
            end
        end

        assign w_pressed = ~r_sync2;

        // Debounce: the level must differ from db for DEBOUNCE_CYCLES clocks in a row.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db   <= 1'b0;
                r_dcnt <= '0;
            end else if (w_pressed != r_db) begin
                if (r_dcnt == c_db_last) begin
                    r_db   <= w_pressed;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end else begin
                r_dcnt <= '0;
            end
        end

        // Delayed copy of db for rising-edge detection.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_db_q <= 1'b0;
            end else begin
                r_db_q <= r_db;
            end
        end

        // Press only (0->1); release and hold produce no step.
        assign w_step[gi] = r_db & ~r_db_q;
    end

    assign w_inc = w_step[0];
    assign w_dec = w_step[1];

    logic [DW-1:0] r_duty;
    logic [DW-1:0] r_duty_act;
    logic [CW-1:0] r_cnt;

    // Duty register: saturating step, compare before arithmetic, both pulses cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty <= c_duty_rst;
        end else if (w_inc && !w_dec) begin
            r_duty <= (r_duty >= c_inc_lim) ? c_duty_max : (r_duty + c_step);
        end else if (w_dec && !w_inc) begin
            r_duty <= (r_duty < c_step) ? '0 : (r_duty - c_step);
        end
    end

    // Free-running period counter 0..PERIOD_CYCLES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow duty picked up on the last count so the new value starts a fresh period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty_act <= c_duty_rst;
        end else if (r_cnt == c_cnt_last) begin
            r_duty_act <= r_duty;
        end
    end

    // Registered compare: high for exactly duty_act cycles of each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (DW'(r_cnt) < r_duty_act);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm
//  Description : Self-checking bench for pwm. Expected high-times are queued
//                when button stimulus is applied and compared against whole
//                measured PWM periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic pb_inc  = 1'b1;
    logic pb_dec  = 1'b1;
    logic pb_inc8 = 1'b1;
    logic pb_dec8 = 1'b1;
    logic pwm_o;
    logic pwm_o8;

    int n;
    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #10 clk = ~clk;

    pwm dut (
        .clk     (clk),
        .rst     (rst),
        .pb_inc  (pb_inc),
        .pb_dec  (pb_dec),
        .pwm_out (pwm_o)
    );

    pwm #(.DEBOUNCE_CYCLES(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .pb_inc  (pb_inc8),
        .pb_dec  (pb_dec8),
        .pwm_out (pwm_o8)
    );

    // Clock edges since reset release; sample n-1 corresponds to counter phase.
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(3);
        @(negedge clk);
        rst = 1'b1;
        step(1);
    endtask

    // Waits for a period start, then counts high samples over one full period.
    task automatic measure(input bit sel, output int high);
        int guard;
        guard = 0;
        while ((((n - 1) % 100) != 0) && (guard < 200)) begin
            step(1);
            guard++;
        end
        high = 0;
        for (int i = 0; i < 100; i++) begin
            if ((sel ? pwm_o8 : pwm_o) === 1'b1) high++;
            step(1);
        end
    endtask

    task automatic press(input bit sel, input bit inc, input bit dec, input int len);
        if (sel) begin
            pb_inc8 = ~inc;
            pb_dec8 = ~dec;
        end else begin
            pb_inc = ~inc;
            pb_dec = ~dec;
        end
        step(len);
        pb_inc  = 1'b1;
        pb_dec  = 1'b1;
        pb_inc8 = 1'b1;
        pb_dec8 = 1'b1;
        step(sel ? 20 : 12);
    endtask

    task automatic test_reset();
        logic e;
        #5;
        rst = 1'b0;
        #3;
        checks++;
        if (pwm_o !== 1'b0) begin errors++; $display("FAIL reset_async got %b expected 0", pwm_o); end
        step(3);
        checks++;
        if (pwm_o8 !== 1'b0) begin errors++; $display("FAIL reset_hold got %b expected 0", pwm_o8); end
        @(negedge clk);
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 200; i++) begin
            e = ((i % 100) < 50);
            checks++;
            if (pwm_o !== e) begin
                errors++;
                $display("FAIL reset_wave cycle %0d got %b expected %b", i, pwm_o, e);
            end
            step(1);
        end
    endtask

    task automatic test_single_inc();
        int h1, h2, e;
        do_reset();
        exp_q.push_back(50);
        exp_q.push_back(60);
        fork
            measure(1'b0, h1);
            begin
                step(10);
                press(1'b0, 1'b1, 1'b0, 2);
            end
        join
        e = exp_q.pop_front();
        checks++;
        if (h1 !== e) begin errors++; $display("FAIL inc_boundary high %0d expected %0d", h1, e); end
        measure(1'b0, h2);
        e = exp_q.pop_front();
        checks++;
        if (h2 !== e) begin errors++; $display("FAIL inc_single high %0d expected %0d", h2, e); end
    endtask

    task automatic test_back_to_back();
        int h, e;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                press(1'b0, 1'b1, 1'b0, 2);
                exp_q.push_back(60);
            end else begin
                press(1'b0, 1'b0, 1'b1, 2);
                exp_q.push_back(50);
            end
            measure(1'b0, h);
            e = exp_q.pop_front();
            checks++;
            if (h !== e) begin errors++; $display("FAIL seq_%0d high %0d expected %0d", k, h, e); end
        end
    endtask

    task automatic test_saturation();
        int h, e;
        do_reset();
        for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b0, 2);
        exp_q.push_back(100);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL sat_top_exact high %0d expected %0d", h, e); end
        press(1'b0, 1'b1, 1'b0, 2);
        exp_q.push_back(100);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL sat_top high %0d expected %0d", h, e); end
        for (int k = 0; k < 10; k++) press(1'b0, 1'b0, 1'b1, 2);
        exp_q.push_back(0);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL sat_bot_exact high %0d expected %0d", h, e); end
        press(1'b0, 1'b0, 1'b1, 2);
        exp_q.push_back(0);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL sat_bot high %0d expected %0d", h, e); end
    endtask

    task automatic test_glitch_hold();
        int h, e;
        do_reset();
        press(1'b0, 1'b1, 1'b0, 1);
        exp_q.push_back(50);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL glitch_short high %0d expected %0d", h, e); end
        press(1'b1, 1'b1, 1'b0, 5);
        exp_q.push_back(50);
        measure(1'b1, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL glitch_db8 high %0d expected %0d", h, e); end
        press(1'b1, 1'b1, 1'b0, 1000);
        exp_q.push_back(60);
        measure(1'b1, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL hold_db8 high %0d expected %0d", h, e); end
    endtask

    task automatic test_simultaneous();
        int h, e;
        do_reset();
        press(1'b0, 1'b1, 1'b1, 2);
        exp_q.push_back(50);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL both_pressed high %0d expected %0d", h, e); end
    endtask

    task automatic test_reset_mid();
        int h, e;
        do_reset();
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 1'b0, 2);
        exp_q.push_back(80);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL mid_duty80 high %0d expected %0d", h, e); end
        step(30);
        checks++;
        if (pwm_o !== 1'b1) begin errors++; $display("FAIL mid_before got %b expected 1", pwm_o); end
        #4;
        rst = 1'b0;
        #1;
        checks++;
        if (pwm_o !== 1'b0) begin errors++; $display("FAIL mid_async got %b expected 0", pwm_o); end
        step(2);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        exp_q.push_back(50);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL mid_resume high %0d expected %0d", h, e); end
    endtask

    task automatic test_held_reset();
        int h, e;
        rst    = 1'b0;
        pb_inc = 1'b0;
        step(3);
        @(negedge clk);
        rst = 1'b1;
        step(10);
        pb_inc = 1'b1;
        step(10);
        exp_q.push_back(60);
        measure(1'b0, h);
        e = exp_q.pop_front();
        checks++;
        if (h !== e) begin errors++; $display("FAIL held_reset high %0d expected %0d", h, e); end
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_back_to_back();
        test_saturation();
        test_glitch_hold();
        test_simultaneous();
        test_reset_mid();
        test_held_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
